// File: rtl/serial_pkg.sv
// Shared definitions for the single-bit serial link: FSM state encoding and
// the counter-width helper used by the transmitter and the sequence detectors.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // Counter width for a count range of n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register presenting the next serial bit on q_bit.
// Vacated positions fill with zero, so an empty register drives q_bit low.
module serial_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] sreg;

  // NOTE: the data register is cleared on reset too, so a word abandoned
  // mid-shift can never leak stale bits onto the line afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= d;
    end else if (shift) begin
      sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign q_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready, sends it one
// bit per clock on x_out, then idles for GAP cycles before taking the next word.
module serial_bit_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int GAP       = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = clog2_min1(WIDTH);
  localparam int GW = clog2_min1(GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t         state, state_nx;
  logic [BW-1:0]  bit_cnt, bit_cnt_nx;
  logic [GW-1:0]  gap_cnt, gap_cnt_nx;
  logic           last_bit, accept, load, shift, q_bit;

  assign last_bit = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);

  // Ready is held low during reset so nothing is accepted on a reset edge.
  assign in_ready = !reset && ((state == ST_IDLE) || ((GAP == 0) && last_bit));
  assign accept   = in_valid && in_ready;

  // NOTE: every signal this block drives gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = '0;
    gap_cnt_nx = '0;
    load       = accept;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift = !load;
        if (!last_bit)   bit_cnt_nx = bit_cnt + BW'(1);
        else if (GAP > 0) state_nx  = ST_GAP;
        else if (accept)  state_nx  = ST_SHIFT;
        else              state_nx  = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx   = ST_IDLE;
        else                     gap_cnt_nx = gap_cnt + GW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (in_data),
    .q_bit (q_bit)
  );

  // Outputs decode flops only; none has a combinational path from the inputs.
  assign x_valid = (state == ST_SHIFT);
  assign x_out   = q_bit && x_valid;
  assign busy    = (state != ST_IDLE);
  assign done    = last_bit;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Self-checking bench for serial_bit_tx: three instances (LSB/GAP1, MSB/GAP1,
// LSB/GAP0) exercised by directed vectors and a timeline-based random model.
module tb_serial_bit_tx;

  localparam int W = 8;
  localparam int TL = 4096;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] in_data  [3];
  logic         in_valid [3];
  logic         in_ready [3];
  logic         x_out    [3];
  logic         x_valid  [3];
  logic         busy     [3];
  logic         done     [3];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  serial_bit_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(1)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .x_out(x_out[0]), .x_valid(x_valid[0]),
    .busy(busy[0]), .done(done[0]));

  serial_bit_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .x_out(x_out[1]), .x_valid(x_valid[1]),
    .busy(busy[1]), .done(done[1]));

  serial_bit_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) dut2 (
    .clock(clock), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .x_out(x_out[2]), .x_valid(x_valid[2]),
    .busy(busy[2]), .done(done[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected stream is written in transmission order, first bit leftmost.
  typedef struct {
    int           d;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Sends one word to a GAP=1 instance from idle and checks bits, done and gap.
  task automatic send_vec(input int d, input logic [W-1:0] data,
                          input logic [W-1:0] exp, input string name);
    logic [W-1:0] stream, dmask;
    logic         xv_all;
    @(posedge clock); #1;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    @(negedge clock);
    check({name, "_ready"}, 32'(in_ready[d]), 32'd1);
    @(posedge clock); #1;
    in_valid[d] = 1'b0;
    in_data[d]  = ~data;
    stream = '0; dmask = '0; xv_all = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clock);
      stream[W-1-i] = x_out[d];
      dmask[W-1-i]  = done[d];
      xv_all        = xv_all & x_valid[d];
    end
    check({name, "_bits"}, 32'(stream), 32'(exp));
    check({name, "_done"}, 32'(dmask), 32'h01);
    check({name, "_xv"}, 32'(xv_all), 32'd1);
    @(negedge clock);
    check({name, "_gap"}, {29'd0, x_valid[d], in_ready[d], busy[d]}, 32'b001);
    @(negedge clock);
    check({name, "_idle"}, {30'd0, in_ready[d], busy[d]}, 32'b10);
  endtask

  // Reference timeline: an accepted word occupies the next W cycles, then GAP idle cycles.
  bit exp_xv [TL];
  bit exp_x  [TL];
  bit exp_dn [TL];
  bit exp_bz [TL];

  task automatic run_random(input int d, input int gap, input bit msb, input int nwords);
    int           c = 0;
    int           ready_from = 0;
    int           words = 0;
    logic [W-1:0] word;
    bit           exp_ready;
    for (int i = 0; i < TL; i++) begin
      exp_xv[i] = 0; exp_x[i] = 0; exp_dn[i] = 0; exp_bz[i] = 0;
    end
    while ((words < nwords || c < ready_from + 1) && c < TL - 32) begin
      @(posedge clock); #1;
      in_valid[d] = (words < nwords) && ($urandom_range(0, 3) != 0);
      in_data[d]  = (words == 0) ? 8'b01101101 : W'($urandom);
      @(negedge clock);
      c++;
      exp_ready = (c >= ready_from);
      check($sformatf("rnd%0d_ready_c%0d", d, c), 32'(in_ready[d]), 32'(exp_ready));
      check($sformatf("rnd%0d_xv_c%0d", d, c), 32'(x_valid[d]), 32'(exp_xv[c]));
      check($sformatf("rnd%0d_x_c%0d", d, c), 32'(x_out[d]), 32'(exp_x[c]));
      check($sformatf("rnd%0d_done_c%0d", d, c), 32'(done[d]), 32'(exp_dn[c]));
      check($sformatf("rnd%0d_busy_c%0d", d, c), 32'(busy[d]), 32'(exp_bz[c]));
      if (in_valid[d] && exp_ready) begin
        word = in_data[d];
        for (int i = 0; i < W; i++) begin
          exp_xv[c+1+i] = 1;
          exp_bz[c+1+i] = 1;
          exp_x[c+1+i]  = msb ? word[W-1-i] : word[i];
        end
        exp_dn[c+W] = 1;
        for (int i = 1; i <= gap; i++) exp_bz[c+W+i] = 1;
        ready_from = (gap > 0) ? c + W + gap + 1 : c + W;
        words++;
      end
    end
    check($sformatf("rnd%0d_words", d), 32'(words), 32'(nwords));
    @(posedge clock); #1;
    in_valid[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] xv16, x16, dn16, rdy16;
    logic        dn_seen;

    vecs[0] = '{0, 8'hB4, 8'b00101101};
    vecs[1] = '{1, 8'hB4, 8'b10110100};
    vecs[2] = '{0, 8'h01, 8'b10000000};
    vecs[3] = '{1, 8'h01, 8'b00000001};
    vecs[4] = '{0, 8'h80, 8'b00000001};
    vecs[5] = '{1, 8'h80, 8'b10000000};
    vecs[6] = '{0, 8'h35, 8'b10101100};
    vecs[7] = '{1, 8'h35, 8'b00110101};

    // Reset held for two edges with in_valid high.
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = 8'hAA;
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      @(negedge clock);
      for (int d = 0; d < 3; d++)
        check($sformatf("rst%0d_dut%0d", k, d),
              {29'd0, x_valid[d], in_ready[d], done[d]}, 32'b000);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 3; d++)
      check($sformatf("rel_ready_dut%0d", d), 32'(in_ready[d]), 32'd1);

    // Directed single words.
    for (int i = 0; i < 8; i++)
      send_vec(vecs[i].d, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

    // GAP=0 back-to-back: FF then 00 with in_valid held high.
    @(posedge clock); #1;
    in_valid[2] = 1'b1;
    in_data[2]  = 8'hFF;
    @(negedge clock);
    check("b2b_ready0", 32'(in_ready[2]), 32'd1);
    @(posedge clock); #1;
    in_data[2] = 8'h00;
    xv16 = '0; x16 = '0; dn16 = '0; rdy16 = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      xv16[i-1]  = x_valid[2];
      x16[i-1]   = x_out[2];
      dn16[i-1]  = done[2];
      rdy16[i-1] = in_ready[2];
      if (i == 8) begin
        @(posedge clock); #1;
        in_valid[2] = 1'b0;
      end
    end
    check("b2b_xv", 32'(xv16), 32'hFFFF);
    check("b2b_bits", 32'(x16), 32'h00FF);
    check("b2b_done", 32'(dn16), 32'h8080);
    check("b2b_ready", 32'(rdy16), 32'h8080);
    @(negedge clock);
    check("b2b_after", {29'd0, x_valid[2], busy[2], done[2]}, 32'b000);

    // Reset while bit 3 of A5 is on the line.
    @(posedge clock); #1;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    @(posedge clock); #1;
    in_valid[0] = 1'b0;
    dn_seen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      dn_seen = dn_seen | done[0];
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_bit3", {30'd0, x_valid[0], x_out[0]}, 32'b10);
    dn_seen = dn_seen | done[0];
    @(posedge clock); #1;
    @(negedge clock);
    dn_seen = dn_seen | done[0];
    check("mid_rst_out", {29'd0, x_valid[0], busy[0], done[0]}, 32'b000);
    check("mid_no_done", 32'(dn_seen), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rel_ready", 32'(in_ready[0]), 32'd1);
    send_vec(0, 8'h0F, 8'b11110000, "mid_fresh");

    // Randomized scoreboard runs, first word 8'b01101101 on each.
    run_random(0, 1, 1'b0, 100);
    run_random(1, 1, 1'b1, 100);
    run_random(2, 0, 1'b0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
